wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency result unit (multiply/divide or late load return). Pipeline writes have priority; long-latency results wait in a 2-entry queue and are drained in idle slots, or by a forced one-cycle pipeline stall when the queue is full or its head is starving. The block also exports a busy vector of registers with queued results, so the decode stage can interlock. It sits between the write stage outputs and the register file write port.

## Interface
- DATA_W, 32, write data width
- REG_W, 3, register address width (8 registers)
- STARVE_LIMIT, 8, cycles a queued head may wait before a forced drain (1..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- pipe_wr_en  in  1  write stage requests a register write this cycle
- pipe_wr_reg  in  REG_W  write stage destination
- pipe_wr_data  in  DATA_W  write stage data (ALU or memory result, already selected)
- lu_valid  in  1  long-latency unit presents a result
- lu_reg  in  REG_W  its destination
- lu_data  in  DATA_W  its data
- lu_ready  out  1  queue accepts a result this cycle
- pipe_stall  out  1  pipeline must hold the write stage contents this cycle
- rf_wr_en  out  1  register file write enable (registered)
- rf_wr_reg  out  REG_W  register file address (registered)
- rf_wr_data  out  DATA_W  register file data (registered)
- lu_busy  out  2**REG_W  bit r set while a live queued entry targets register r

## Operation
- Queue: 2 entries, each {live, reg, data}; head/tail pointers plus count 0..2.
- drain_req = (count==2) or (count>0 and age>=STARVE_LIMIT); decoded from registered state only.
- Grant per cycle, in priority order:
  - drain_req: pipe_stall=1, pipe write ignored (pipeline re-presents it next cycle), head popped; written to RF if live.
  - pipe_wr_en: pipe write granted.
  - count>0: head popped, written if live.
  - otherwise: no write.
- Kill: a granted pipe write whose reg matches a live queued entry clears that entry's live bit (newer write wins). An entry pushed in the same cycle is not killed.
- Dead head pops in an idle slot or forced drain with rf_wr_en=0.
- lu_ready = rst_n and (count<2); push occurs on lu_valid and lu_ready.
- Push and pop in the same cycle: count unchanged.
- Age: 4-bit counter. Cleared on pop or when count==0; otherwise increments, saturating at 15.
- lu_busy: OR over live entries, decoded from registered state.

## Timing
- RF outputs register the granted write: 1-cycle latency from grant to rf_wr_*.
- pipe_stall, lu_ready, lu_busy are combinational from registered state. They have no combinational path from the pipe_* or lu_* inputs.
- Forced drain lasts exactly one cycle per pop. With count==2, two consecutive stall cycles occur unless a push refills the queue.
- Reset (any cycle, including mid-drain): count=0, all live bits 0, age=0, rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, pipe_stall=0, lu_busy=0, lu_ready=0 while rst_n is low. Queued results are discarded.

## Structure
- Package wb_arb_pkg: DATA_W, REG_W, NUM_REGS, and the typedef wb_entry_t {live, reg, data}.
- One sub-module, wb_arb_fifo: 2-entry queue with push, pop, kill-by-reg, count and live outputs.
- Top level: grant logic, age counter, output registers.

## Test plan
- Idle queue, pipe_wr_en=1, reg 3, data 0x1234 -> next cycle rf_wr_en=1, rf_wr_reg=3, rf_wr_data=0x1234; pipe_stall=0 throughout.
- lu_valid, reg 5, data 0xAA, with no pipe traffic -> lu_busy[5]=1 for one cycle; queued result written the following cycle (RF shows reg 5 / 0xAA); lu_busy returns to 0.
- Push two LU results while pipe_wr_en is held high -> count 2, lu_ready=0, pipe_stall=1 for 2 cycles, both LU writes appear in order, then the held pipe write lands.
- One LU entry plus continuous pipe writes -> pipe_stall asserted on the cycle age reaches 8; LU write appears; pipe resumes.
- Queue reg 2 (0x11), then pipe write reg 2 (0x22) -> entry killed, lu_busy[2] clears, only 0x22 is written to reg 2, dead pop produces rf_wr_en=0.
- rst_n low with count 2 during a drain -> next cycle all outputs at reset values, queue empty, no stale write after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared widths and the queue entry type for the register-file write-port
//   arbiter (wb_port_arbiter) and its result queue (wb_arb_fifo).
//
//   DATA_W   : register write data width
//   REG_W    : register address width
//   NUM_REGS : number of architectural registers (width of the busy vector)
//   AGE_W    : width of the head-of-queue age counter (saturates at all-ones)
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 3;
    localparam int NUM_REGS = 1 << REG_W;
    localparam int AGE_W    = 4;

    // One queued long-latency result. live drops when a newer pipeline write
    // to the same register makes the queued value obsolete.
    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  wr_reg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// -----------------------------------------------------------------------------
// wb_arb_fifo
//   Two-entry in-order queue of long-latency results waiting for the register
//   file write port.
//
//   clk, rst_n   : clock, synchronous active-low reset (empties the queue)
//   i_push       : enqueue {i_push_reg, i_push_data} as a live entry
//   i_pop        : dequeue the head entry
//   i_kill       : clear the live bit of every queued entry targeting
//                  i_kill_reg (an entry pushed this same cycle is unaffected)
//   o_count      : number of occupied slots, 0..2
//   o_head       : head entry (meaningful when o_count != 0)
//   o_busy       : bit r set while a live queued entry targets register r
// -----------------------------------------------------------------------------
module wb_arb_fifo
    import wb_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [REG_W-1:0]    i_push_reg,
    input  logic [DATA_W-1:0]   i_push_data,
    input  logic                i_pop,
    input  logic                i_kill,
    input  logic [REG_W-1:0]    i_kill_reg,
    output logic [1:0]          o_count,
    output wb_entry_t           o_head,
    output logic [NUM_REGS-1:0] o_busy
);

    wb_entry_t r_mem [2];
    logic      r_head;
    logic      r_tail;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Kill looks only at registered contents, so a same-cycle push
            // (written below into the free tail slot) survives.
            for (int i = 0; i < 2; i++) begin
                if (i_kill && r_mem[i].live && (r_mem[i].wr_reg == i_kill_reg)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            // A popped slot loses its live bit so it no longer shows as busy.
            if (w_pop) begin
                r_mem[r_head].live <= 1'b0;
                r_head             <= ~r_head;
            end
            if (w_push) begin
                r_mem[r_tail] <= '{live: 1'b1, wr_reg: i_push_reg, data: i_push_data};
                r_tail        <= ~r_tail;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < 2; i++) begin
            if (r_mem[i].live) begin
                o_busy[r_mem[i].wr_reg] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   stage and a long-latency result unit. Pipeline writes win; long-latency
//   results wait in a 2-entry queue and drain in idle slots, or through a
//   one-cycle pipeline stall per pop when the queue is full or its head has
//   waited STARVE_LIMIT cycles.
//
//   Parameter STARVE_LIMIT (1..15): head age that forces a drain.
//   clk, rst_n                 : clock, synchronous active-low reset
//   pipe_wr_en/_reg/_data      : write stage request
//   lu_valid/_reg/_data        : long-latency unit result
//   lu_ready                   : queue accepts a result this cycle
//   pipe_stall                 : write stage must hold its contents
//   rf_wr_en/_reg/_data        : registered register-file write port
//   lu_busy                    : registers with a live queued result
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pipe_wr_en,
    input  logic [REG_W-1:0]    pipe_wr_reg,
    input  logic [DATA_W-1:0]   pipe_wr_data,
    input  logic                lu_valid,
    input  logic [REG_W-1:0]    lu_reg,
    input  logic [DATA_W-1:0]   lu_data,
    output logic                lu_ready,
    output logic                pipe_stall,
    output logic                rf_wr_en,
    output logic [REG_W-1:0]    rf_wr_reg,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic [NUM_REGS-1:0] lu_busy
);

    localparam logic [AGE_W-1:0] LP_STARVE = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] LP_AGE_MAX = '1;

    logic [1:0]          w_count;
    wb_entry_t           w_head;
    logic [NUM_REGS-1:0] w_busy;

    logic w_drain;
    logic w_pipe_grant;
    logic w_pop;
    logic w_push;
    logic w_lu_ready;

    logic [AGE_W-1:0]  r_age;
    logic              r_flush;
    logic              r_rf_en;
    logic [REG_W-1:0]  r_rf_reg;
    logic [DATA_W-1:0] r_rf_data;

    wb_arb_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_reg  (lu_reg),
        .i_push_data (lu_data),
        .i_pop       (w_pop),
        .i_kill      (w_pipe_grant),
        .i_kill_reg  (pipe_wr_reg),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_busy      (w_busy)
    );

    // Forced drain depends on registered state only. r_flush keeps the stall
    // going after a pop from a full queue, so a full queue empties in two
    // back-to-back stall cycles.
    assign w_drain = (w_count == 2'd2) ||
                     ((w_count != 2'd0) && ((r_age >= LP_STARVE) || r_flush));

    assign w_pipe_grant = pipe_wr_en && !w_drain;
    assign w_pop        = w_drain || (!pipe_wr_en && (w_count != 2'd0));
    assign w_lu_ready   = rst_n && (w_count != 2'd2);
    assign w_push       = lu_valid && w_lu_ready;

    assign lu_ready   = w_lu_ready;
    assign pipe_stall = rst_n && w_drain;
    assign lu_busy    = rst_n ? w_busy : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_age     <= '0;
            r_flush   <= 1'b0;
            r_rf_en   <= 1'b0;
            r_rf_reg  <= '0;
            r_rf_data <= '0;
        end else begin
            if (w_pipe_grant) begin
                r_rf_en   <= 1'b1;
                r_rf_reg  <= pipe_wr_reg;
                r_rf_data <= pipe_wr_data;
            end else if (w_pop) begin
                // A killed (dead) head consumes the slot without writing.
                r_rf_en   <= w_head.live;
                r_rf_reg  <= w_head.wr_reg;
                r_rf_data <= w_head.data;
            end else begin
                r_rf_en   <= 1'b0;
            end

            if (w_pop || (w_count == 2'd0)) begin
                r_age <= '0;
            end else if (r_age != LP_AGE_MAX) begin
                r_age <= r_age + 1'b1;
            end

            r_flush <= w_drain && (w_count == 2'd2);
        end
    end

    assign rf_wr_en   = r_rf_en;
    assign rf_wr_reg  = r_rf_reg;
    assign rf_wr_data = r_rf_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter. Inputs change 1 time unit after each
//   rising edge; outputs are sampled at the same point, so rf_* reflect the
//   grant of the previous cycle and pipe_stall/lu_ready/lu_busy reflect the
//   registered state of the current cycle.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                pipe_wr_en;
    logic [REG_W-1:0]    pipe_wr_reg;
    logic [DATA_W-1:0]   pipe_wr_data;
    logic                lu_valid;
    logic [REG_W-1:0]    lu_reg;
    logic [DATA_W-1:0]   lu_data;
    logic                lu_ready;
    logic                pipe_stall;
    logic                rf_wr_en;
    logic [REG_W-1:0]    rf_wr_reg;
    logic [DATA_W-1:0]   rf_wr_data;
    logic [NUM_REGS-1:0] lu_busy;

    int n_cmp;
    int n_bad;

    wb_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_reg  (pipe_wr_reg),
        .pipe_wr_data (pipe_wr_data),
        .lu_valid     (lu_valid),
        .lu_reg       (lu_reg),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .pipe_stall   (pipe_stall),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_reg    (rf_wr_reg),
        .rf_wr_data   (rf_wr_data),
        .lu_busy      (lu_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic en, input logic [REG_W-1:0] r,
                          input logic [DATA_W-1:0] d);
        chk({tag, ".en"}, 64'(rf_wr_en), 64'(en));
        if (en) begin
            chk({tag, ".reg"}, 64'(rf_wr_reg), 64'(r));
            chk({tag, ".data"}, 64'(rf_wr_data), 64'(d));
        end
    endtask

    task automatic set_pipe(input logic en, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        pipe_wr_en   = en;
        pipe_wr_reg  = r;
        pipe_wr_data = d;
    endtask

    task automatic set_lu(input logic v, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        lu_valid = v;
        lu_reg   = r;
        lu_data  = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        tick();
        tick();

        // Reset state
        chk("rst.rf_en",   64'(rf_wr_en),   64'd0);
        chk("rst.rf_reg",  64'(rf_wr_reg),  64'd0);
        chk("rst.rf_data", 64'(rf_wr_data), 64'd0);
        chk("rst.stall",   64'(pipe_stall), 64'd0);
        chk("rst.busy",    64'(lu_busy),    64'd0);
        chk("rst.ready",   64'(lu_ready),   64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel.ready", 64'(lu_ready), 64'd1);

        // 1: plain pipe write with an idle queue
        set_pipe(1'b1, 3'd3, 32'h1234);
        chk("p1.stall0", 64'(pipe_stall), 64'd0);
        tick();
        set_pipe(1'b0, '0, '0);
        chk_rf("p1.rf", 1'b1, 3'd3, 32'h1234);
        chk("p1.stall1", 64'(pipe_stall), 64'd0);
        tick();
        chk("p1.idle", 64'(rf_wr_en), 64'd0);

        // 2: single LU result drained in an idle slot
        set_lu(1'b1, 3'd5, 32'hAA);
        chk("l1.ready", 64'(lu_ready), 64'd1);
        tick();
        set_lu(1'b0, '0, '0);
        chk("l1.busy", 64'(lu_busy), 64'h20);
        chk("l1.rf_idle", 64'(rf_wr_en), 64'd0);
        tick();
        chk_rf("l1.rf", 1'b1, 3'd5, 32'hAA);
        chk("l1.busy_clr", 64'(lu_busy), 64'h00);

        // 3: fill the queue under pipe traffic -> two forced drains
        set_pipe(1'b1, 3'd1, 32'h101);
        set_lu(1'b1, 3'd6, 32'h66);
        tick();
        chk_rf("f.rf_a", 1'b1, 3'd1, 32'h101);
        set_pipe(1'b1, 3'd2, 32'h202);
        set_lu(1'b1, 3'd7, 32'h77);
        tick();
        set_lu(1'b0, '0, '0);
        set_pipe(1'b1, 3'd3, 32'h303);
        chk_rf("f.rf_b", 1'b1, 3'd2, 32'h202);
        chk("f.ready_full", 64'(lu_ready),   64'd0);
        chk("f.stall1",     64'(pipe_stall), 64'd1);
        chk("f.busy_full",  64'(lu_busy),    64'hC0);
        tick();
        chk("f.stall2",    64'(pipe_stall), 64'd1);
        chk("f.ready_one", 64'(lu_ready),   64'd1);
        chk("f.busy_one",  64'(lu_busy),    64'h80);
        chk_rf("f.rf_lu6", 1'b1, 3'd6, 32'h66);
        tick();
        chk("f.stall_off", 64'(pipe_stall), 64'd0);
        chk("f.busy_none", 64'(lu_busy),    64'h00);
        chk_rf("f.rf_lu7", 1'b1, 3'd7, 32'h77);
        tick();
        set_pipe(1'b0, '0, '0);
        chk_rf("f.rf_held", 1'b1, 3'd3, 32'h303);
        tick();

        // 4: starving head under continuous pipe writes (limit 8)
        set_pipe(1'b1, 3'd0, 32'h500);
        set_lu(1'b1, 3'd4, 32'h44);
        tick();
        set_lu(1'b0, '0, '0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("s.nostall%0d", k), 64'(pipe_stall), 64'd0);
            pipe_wr_data = 32'h500 + 32'(k);
            tick();
        end
        chk("s.stall",   64'(pipe_stall), 64'd1);
        chk("s.busy",    64'(lu_busy),    64'h10);
        chk_rf("s.rf_pre", 1'b1, 3'd0, 32'h508);
        pipe_wr_data = 32'h509;
        tick();
        chk("s.resume", 64'(pipe_stall), 64'd0);
        chk_rf("s.rf_lu", 1'b1, 3'd4, 32'h44);
        tick();
        set_pipe(1'b0, '0, '0);
        chk_rf("s.rf_pipe", 1'b1, 3'd0, 32'h509);
        tick();

        // 5: newer pipe write kills a queued result
        set_lu(1'b1, 3'd2, 32'h11);
        tick();
        set_lu(1'b0, '0, '0);
        chk("k.busy", 64'(lu_busy), 64'h04);
        set_pipe(1'b1, 3'd2, 32'h22);
        tick();
        set_pipe(1'b0, '0, '0);
        chk("k.busy_clr", 64'(lu_busy), 64'h00);
        chk_rf("k.rf_pipe", 1'b1, 3'd2, 32'h22);
        tick();
        chk("k.dead_pop", 64'(rf_wr_en), 64'd0);
        chk("k.ready",    64'(lu_ready), 64'd1);
        tick();
        chk("k.quiet", 64'(rf_wr_en), 64'd0);

        // 5b: same-cycle push to the pipe's register is not killed
        set_pipe(1'b1, 3'd5, 32'h55);
        set_lu(1'b1, 3'd5, 32'h5A);
        tick();
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        chk_rf("n.rf_pipe", 1'b1, 3'd5, 32'h55);
        chk("n.busy", 64'(lu_busy), 64'h20);
        tick();
        chk_rf("n.rf_lu", 1'b1, 3'd5, 32'h5A);
        chk("n.busy_clr", 64'(lu_busy), 64'h00);
        tick();

        // 6: reset in the middle of a forced drain
        set_pipe(1'b1, 3'd0, 32'h1);
        set_lu(1'b1, 3'd1, 32'hA1);
        tick();
        set_lu(1'b1, 3'd2, 32'hA2);
        tick();
        set_lu(1'b0, '0, '0);
        chk("r.stall_pre", 64'(pipe_stall), 64'd1);
        rst_n = 1'b0;
        tick();
        set_pipe(1'b0, '0, '0);
        chk("r.rf_en",   64'(rf_wr_en),   64'd0);
        chk("r.rf_reg",  64'(rf_wr_reg),  64'd0);
        chk("r.rf_data", 64'(rf_wr_data), 64'd0);
        chk("r.stall",   64'(pipe_stall), 64'd0);
        chk("r.busy",    64'(lu_busy),    64'd0);
        chk("r.ready",   64'(lu_ready),   64'd0);
        rst_n = 1'b1;
        tick();
        chk("r.ready_rel", 64'(lu_ready),   64'd1);
        chk("r.stall_rel", 64'(pipe_stall), 64'd0);
        chk("r.busy_rel",  64'(lu_busy),    64'd0);
        chk("r.no_write0", 64'(rf_wr_en),   64'd0);
        tick();
        chk("r.no_write1", 64'(rf_wr_en),   64'd0);
        tick();
        chk("r.no_write2", 64'(rf_wr_en),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
